fmul_share_arb: RTL and testbench

Round-robin arbiter and sequencer that time-shares one pipelined single-precision multiplier (the `fmul` unit, fixed latency) among `NREQ` requesters, e.g. the core FPU issue port and the ray-trace helper units. Each requester gets a valid/ready request channel and a valid/ready response channel. The block tracks in-flight operations with a tag pipeline matched to the multiplier latency, and steers each result back into a per-requester response register. Each requester may have at most one operation outstanding.

---
 rtl/fmul_share_arb.sv | 131 +++++++++++++
 tb/tb_fmul_share_arb.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fmul_share_arb.sv
// Round-robin arbiter that time-shares one fixed-latency pipelined fmul unit
// among NREQ requesters. A {valid, index} tag pipeline follows each issued
// operation through the multiplier so its result lands in the right response slot.
module fmul_share_arb #(
  parameter int NREQ = 2,
  parameter int LAT  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [32*NREQ-1:0]   req_x1,
  input  logic [32*NREQ-1:0]   req_x2,
  output logic [NREQ-1:0]      rsp_valid,
  input  logic [NREQ-1:0]      rsp_ready,
  output logic [32*NREQ-1:0]   rsp_y,
  output logic [31:0]          fmul_x1,
  output logic [31:0]          fmul_x2,
  input  logic [31:0]          fmul_y,
  output logic                 busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [IW-1:0]      ptr_q, ptr_d;
  logic [NREQ-1:0]    pending_q, pending_d;
  logic [NREQ-1:0]    elig;
  logic [NREQ-1:0]    grant_oh;
  logic               grant_any;
  logic [IW-1:0]      grant_idx;
  logic [IW-1:0]      cand;
  logic [NREQ-1:0]    rsp_hs;
  logic [NREQ-1:0]    rsp_valid_q, rsp_valid_d;
  logic [32*NREQ-1:0] rsp_y_q;
  logic [LAT-1:0]     tag_vld_q;
  logic [IW-1:0]      tag_idx_q [LAT];
  logic               cap_vld;
  logic [IW-1:0]      cap_idx;

  // Round-robin search from ptr; a requester with an operation outstanding is skipped
  always_comb begin
    elig      = req_valid & ~pending_q & {NREQ{~rst}};
    grant_oh  = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int off = 0; off < NREQ; off++) begin
      cand = IW'((int'(ptr_q) + off) % NREQ);
      if (!grant_any && elig[cand]) begin
        grant_any      = 1'b1;
        grant_idx      = cand;
        grant_oh[cand] = 1'b1;
      end
    end
    ptr_d = grant_any ? IW'((int'(grant_idx) + 1) % NREQ) : ptr_q;
  end

  // Operand steering to the multiplier; zero when nothing issues
  always_comb begin
    fmul_x1 = '0;
    fmul_x2 = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_oh[i]) begin
        fmul_x1 = req_x1[32*i +: 32];
        fmul_x2 = req_x2[32*i +: 32];
      end
    end
  end

  assign req_ready = grant_oh;
  assign rsp_hs    = rsp_valid_q & rsp_ready;
  assign pending_d = (pending_q & ~rsp_hs) | grant_oh;
  assign cap_vld   = tag_vld_q[LAT-1];
  assign cap_idx   = tag_idx_q[LAT-1];

  // Response valid: set when the tag pipeline delivers, cleared on handshake
  always_comb begin
    rsp_valid_d = rsp_valid_q & ~rsp_hs;
    for (int i = 0; i < NREQ; i++) begin
      if (cap_vld && cap_idx == IW'(i)) begin
        rsp_valid_d[i] = 1'b1;
      end
    end
  end

  // Control state: pointer, pending bits, tag valids, response valids
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      pending_q   <= '0;
      tag_vld_q   <= '0;
      rsp_valid_q <= '0;
    end else begin
      ptr_q        <= ptr_d;
      pending_q    <= pending_d;
      rsp_valid_q  <= rsp_valid_d;
      // issue -> stage 0 of the tag pipeline
      tag_vld_q[0] <= grant_any;
      for (int k = 1; k < LAT; k++) begin
        // stage k-1 -> stage k
        tag_vld_q[k] <= tag_vld_q[k-1];
      end
    end
  end

  // Tag indices travel alongside the valids; only meaningful when valid
  always_ff @(posedge clk) begin
    tag_idx_q[0] <= grant_idx;
    for (int k = 1; k < LAT; k++) begin
      tag_idx_q[k] <= tag_idx_q[k-1];
    end
  end

  // Result capture into the per-requester response register
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_y_q <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (cap_vld && cap_idx == IW'(i)) begin
          rsp_y_q[32*i +: 32] <= fmul_y;
        end
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_y     = rsp_y_q;
  assign busy      = |pending_q;

endmodule

// File: tb/tb_fmul_share_arb.sv
// Bench for fmul_share_arb: a 2-port/LAT=1 instance driven by a cycle table and
// hand sequences, and a 4-port/LAT=3 instance driven randomly. A queue-based
// scoreboard checks every product, response latency and result stability.
module tb_fmul_share_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   resp4 = 0;

  logic [1:0]   rv2, rdy2, rspv2, rr2;
  logic [63:0]  x1_2, x2_2, y2;
  logic [31:0]  fx1_2, fx2_2, fy2;
  logic         busy2;

  logic [3:0]   rv4, rdy4, rspv4, rr4;
  logic [127:0] x1_4, x2_4, y4;
  logic [31:0]  fx1_4, fx2_4, fy4;
  logic         busy4;

  fmul_share_arb #(.NREQ(2), .LAT(1)) dut2 (
    .clk(clk), .rst(rst), .req_valid(rv2), .req_ready(rdy2), .req_x1(x1_2), .req_x2(x2_2),
    .rsp_valid(rspv2), .rsp_ready(rr2), .rsp_y(y2), .fmul_x1(fx1_2), .fmul_x2(fx2_2),
    .fmul_y(fy2), .busy(busy2));

  fmul_share_arb #(.NREQ(4), .LAT(3)) dut4 (
    .clk(clk), .rst(rst), .req_valid(rv4), .req_ready(rdy4), .req_x1(x1_4), .req_x2(x2_4),
    .rsp_valid(rspv4), .rsp_ready(rr4), .rsp_y(y4), .fmul_x1(fx1_4), .fmul_x2(fx2_4),
    .fmul_y(fy4), .busy(busy4));

  // Reference multiply for normal operands (truncating); zero exponent gives signed zero
  function automatic logic [31:0] fm(input logic [31:0] a, input logic [31:0] b);
    logic        s;
    int          e;
    logic [23:0] ma, mb;
    logic [47:0] m;
    s = a[31] ^ b[31];
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {s, 31'd0};
    ma = {1'b1, a[22:0]};
    mb = {1'b1, b[22:0]};
    m  = ma * mb;
    e  = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (m[47]) begin
      e = e + 1;
      return {s, e[7:0], m[46:24]};
    end
    return {s, e[7:0], m[45:23]};
  endfunction

  function automatic logic [31:0] rnd_op();
    logic [7:0] e;
    e = 8'($urandom_range(154, 100));
    return {1'($urandom_range(1, 0)), e, 23'($urandom)};
  endfunction

  // Multiplier models with the latency each instance expects
  logic [31:0] m2_q;
  logic [31:0] m4_q [3];
  always @(posedge clk) begin
    m2_q    <= fm(fx1_2, fx2_2);
    m4_q[0] <= fm(fx1_4, fx2_4);
    m4_q[1] <= m4_q[0];
    m4_q[2] <= m4_q[1];
  end
  assign fy2 = m2_q;
  assign fy4 = m4_q[2];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int          id;
    int          port;
    logic [31:0] y;
    int          cyc;
  } sb_t;
  sb_t sb[$];

  logic        prev_v  [2][4];
  logic        prev_hs [2][4];
  logic [31:0] prev_y  [2][4];

  function automatic int find(input int id, input int p);
    for (int k = 0; k < sb.size(); k++)
      if (sb[k].id == id && sb[k].port == p) return k;
    return -1;
  endfunction

  task automatic mon(input int id, input int n, input int lat,
                     input logic [3:0] rdy, input logic [3:0] rspv, input logic [3:0] rr,
                     input logic [127:0] x1, input logic [127:0] x2, input logic [127:0] y,
                     input logic rstv);
    if (rstv) begin
      for (int k = sb.size() - 1; k >= 0; k--)
        if (sb[k].id == id) sb.delete(k);
      for (int p = 0; p < 4; p++) begin
        prev_v[id][p]  = 1'b0;
        prev_hs[id][p] = 1'b0;
      end
      return;
    end
    chk("ready_onehot0", $onehot0(rdy), 1);
    for (int p = 0; p < n; p++) begin
      int          k;
      logic [31:0] yp;
      sb_t         e;
      k  = find(id, p);
      yp = y[32*p +: 32];
      if (rspv[p] && !prev_v[id][p]) begin
        chk("rsp_has_request", k >= 0, 1);
        if (k >= 0) chk("rsp_latency", cyc - sb[k].cyc, lat + 1);
      end
      if (rspv[p] && prev_v[id][p] && !prev_hs[id][p])
        chk("rsp_y_stable", yp, prev_y[id][p]);
      if (rspv[p] && rr[p] && k >= 0) begin
        chk("rsp_y_product", yp, sb[k].y);
        sb.delete(k);
        if (id == 1) resp4++;
      end
      if (rdy[p]) begin
        chk("grant_while_outstanding", find(id, p) >= 0, 0);
        e = '{id, p, fm(x1[32*p +: 32], x2[32*p +: 32]), cyc};
        sb.push_back(e);
      end
      prev_v[id][p]  = rspv[p];
      prev_hs[id][p] = rspv[p] & rr[p];
      prev_y[id][p]  = yp;
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    mon(0, 2, 1, {2'b0, rdy2}, {2'b0, rspv2}, {2'b0, rr2}, {64'b0, x1_2}, {64'b0, x2_2},
        {64'b0, y2}, rst);
    mon(1, 4, 3, rdy4, rspv4, rr4, x1_4, x2_4, y4, rst);
  end

  typedef struct {
    logic [1:0]  rv, rr;
    logic [31:0] a0, b0, a1, b1;
    logic [1:0]  rdy, rspv;
    logic        busy;
    logic        chky;
    logic [31:0] y0;
  } vec_t;
  vec_t tv[17];

  int g1;

  initial begin
    tv[0]  = '{2'b01, 2'b00, 32'h40000000, 32'h40400000, 32'h0, 32'h0, 2'b01, 2'b00, 1'b0, 1'b0, 32'h0};
    tv[1]  = '{2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 2'b00, 2'b00, 1'b1, 1'b0, 32'h0};
    tv[2]  = '{2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 2'b00, 2'b01, 1'b1, 1'b1, 32'h40C00000};
    tv[3]  = '{2'b00, 2'b01, 32'h0, 32'h0, 32'h0, 32'h0, 2'b00, 2'b01, 1'b1, 1'b1, 32'h40C00000};
    tv[4]  = '{2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 2'b00, 2'b00, 1'b0, 1'b1, 32'h40C00000};
    tv[5]  = '{2'b01, 2'b00, 32'h00000000, 32'h3F800000, 32'h0, 32'h0, 2'b01, 2'b00, 1'b0, 1'b0, 32'h0};
    tv[6]  = '{2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 2'b00, 2'b00, 1'b1, 1'b0, 32'h0};
    tv[7]  = '{2'b00, 2'b01, 32'h0, 32'h0, 32'h0, 32'h0, 2'b00, 2'b01, 1'b1, 1'b1, 32'h00000000};
    tv[8]  = '{2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0};
    tv[9]  = '{2'b11, 2'b11, 32'h3FC00000, 32'h40000000, 32'h40800000, 32'h40800000, 2'b10, 2'b00, 1'b0, 1'b0, 32'h0};
    tv[10] = '{2'b11, 2'b11, 32'h3FC00000, 32'h40000000, 32'h40800000, 32'h40800000, 2'b01, 2'b00, 1'b1, 1'b0, 32'h0};
    tv[11] = '{2'b11, 2'b11, 32'h3FC00000, 32'h40000000, 32'h40800000, 32'h40800000, 2'b00, 2'b10, 1'b1, 1'b0, 32'h0};
    tv[12] = '{2'b11, 2'b11, 32'h3FC00000, 32'h40000000, 32'h40800000, 32'h40800000, 2'b10, 2'b01, 1'b1, 1'b1, 32'h40400000};
    tv[13] = '{2'b11, 2'b11, 32'h3FC00000, 32'h40000000, 32'h40800000, 32'h40800000, 2'b01, 2'b00, 1'b1, 1'b0, 32'h0};
    tv[14] = '{2'b11, 2'b11, 32'h3FC00000, 32'h40000000, 32'h40800000, 32'h40800000, 2'b00, 2'b10, 1'b1, 1'b0, 32'h0};
    tv[15] = '{2'b00, 2'b11, 32'h0, 32'h0, 32'h0, 32'h0, 2'b00, 2'b01, 1'b1, 1'b1, 32'h40400000};
    tv[16] = '{2'b00, 2'b11, 32'h0, 32'h0, 32'h0, 32'h0, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0};

    rst = 1'b1;
    rv2 = '0; rr2 = '0; x1_2 = '0; x2_2 = '0;
    rv4 = '0; rr4 = '0; x1_4 = '0; x2_4 = '0;
    repeat (2) @(posedge clk);
    #1;
    rv2 = 2'b11;
    @(negedge clk);
    chk("reset_req_ready", rdy2, 2'b00);
    chk("reset_rsp_valid", rspv2, 2'b00);
    chk("reset_busy", busy2, 1'b0);
    chk("reset_rsp_y", y2, 64'h0);
    chk("reset_fmul_x1", fx1_2, 32'h0);

    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 17; i++) begin
      rv2  = tv[i].rv;
      rr2  = tv[i].rr;
      x1_2 = {tv[i].a1, tv[i].a0};
      x2_2 = {tv[i].b1, tv[i].b0};
      @(negedge clk);
      chk($sformatf("vec%0d_req_ready", i), rdy2, tv[i].rdy);
      chk($sformatf("vec%0d_rsp_valid", i), rspv2, tv[i].rspv);
      chk($sformatf("vec%0d_busy", i), busy2, tv[i].busy);
      if (tv[i].chky) chk($sformatf("vec%0d_rsp_y0", i), y2[31:0], tv[i].y0);
      @(posedge clk); #1;
    end

    // Backpressure on port 0 while port 1 keeps issuing
    rv2 = 2'b01; rr2 = 2'b10;
    x1_2 = {32'h40000000, 32'hBFC00000};
    x2_2 = {32'h3F800000, 32'h40000000};
    @(negedge clk);
    chk("bp_first_grant", rdy2, 2'b01);
    @(posedge clk); #1;
    g1 = 0;
    for (int i = 0; i < 10; i++) begin
      rv2 = 2'b11; rr2 = 2'b10;
      @(negedge clk);
      chk("bp_no_grant_port0", rdy2[0], 1'b0);
      if (i >= 1) begin
        chk("bp_rsp_valid0", rspv2[0], 1'b1);
        chk("bp_rsp_y0", y2[31:0], 32'hC0400000);
      end
      if (rdy2[1]) g1++;
      @(posedge clk); #1;
    end
    chk("bp_port1_served", g1 >= 3, 1'b1);
    rv2 = 2'b01; rr2 = 2'b11;
    @(negedge clk);
    chk("bp_release_ready", rdy2, 2'b00);
    chk("bp_release_valid0", rspv2[0], 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_regrant_port0", rdy2, 2'b01);
    @(posedge clk); #1;
    rv2 = 2'b00;
    repeat (4) @(posedge clk);
    #1;

    // Reset in the cycle after a grant
    rv2 = 2'b01; rr2 = 2'b11;
    x1_2 = {32'h0, 32'h40000000};
    x2_2 = {32'h0, 32'h40000000};
    @(negedge clk);
    chk("mid_grant", rdy2, 2'b01);
    @(posedge clk); #1;
    rst = 1'b1; rv2 = 2'b00;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("mid_rsp_valid", rspv2, 2'b00);
      chk("mid_busy", busy2, 1'b0);
      chk("mid_rsp_y", y2, 64'h0);
      chk("mid_fmul_x1", fx1_2, 32'h0);
      @(posedge clk); #1;
    end
    rv2 = 2'b11;
    x1_2 = {32'h3F800000, 32'h3F800000};
    x2_2 = {32'h3F800000, 32'h3F800000};
    @(negedge clk);
    chk("ptr_restart", rdy2, 2'b01);
    @(posedge clk); #1;
    rv2 = 2'b00;
    repeat (6) @(posedge clk);
    #1;

    // Random sweep on the 4-port, LAT=3 instance
    for (int c = 0; c < 400; c++) begin
      rv4 = 4'($urandom_range(15, 0));
      rr4 = 4'($urandom_range(15, 0));
      for (int p = 0; p < 4; p++) begin
        x1_4[32*p +: 32] = rnd_op();
        x2_4[32*p +: 32] = rnd_op();
      end
      @(posedge clk); #1;
    end
    rv4 = '0; rr4 = 4'hF;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("sweep_activity", resp4 > 20, 1'b1);
    chk("sweep_busy_idle", busy4, 1'b0);
    chk("scoreboard_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
